// File: rtl/string_tx_pkg.sv
// Shared types and constants for the string buffer transmitter.
// The FSM state type is exported so the debug port and the bench agree on encodings.
package string_tx_pkg;

  typedef enum logic [2:0] {
    COLLECT,
    SEND,
    WAIT_HI,
    WAIT_LO,
    DONE
  } state_t;

  // Source of the character presented to the TX core.
  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_RAM,
    SEL_TERM
  } tx_sel_t;

  localparam int         WAIT_HI_TIMEOUT = 4;
  localparam logic [7:0] DEFAULT_TERM    = 8'h00;

endpackage

// File: rtl/char_buffer_ram.sv
// Character store: one synchronous write port and one registered read port.
// rd_data holds its value until the next rd_en, so it can drive TX directly.
module char_buffer_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                     i_Clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/string_buffer_tx.sv
// Buffers characters from the UART receiver until a terminator arrives, then
// replays them to the UART transmitter forward or reversed, optionally with the terminator.
module string_buffer_tx
  import string_tx_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 256,
  parameter logic [DATA_W-1:0] TERM   = DATA_W'(DEFAULT_TERM),
  parameter int                LEN_W  = $clog2(DEPTH + 1)
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_end,
  input  logic              i_txd_busy,
  input  logic              i_reverse,
  input  logic              i_append_term,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_send_to_computer,
  output logic              o_busy,
  output logic [LEN_W-1:0]  o_len,
  output logic              o_overflow,
  output logic              o_drop,
  output state_t            o_state
);

  localparam int              AW   = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] FULL = LEN_W'(DEPTH);

  // TX handshake: a one-cycle o_send_to_computer pulse hands o_tx_data to the TX
  // core; the core raises i_txd_busy while shifting and the next pulse is only
  // issued once busy has been seen high (or timed out) and then low again.
  state_t            state_q, state_d;
  logic              rx_end_q;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              rev_q, rev_d;
  logic              app_q, app_d;
  logic              term_ph_q, term_ph_d;
  logic [2:0]        wait_q, wait_d;
  logic              ovf_q, ovf_d;
  logic              drop_q, drop_d;
  logic              send_q, send_d;
  tx_sel_t           sel_q, sel_d;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              accept, is_term, last_idx;

  assign accept   = i_rx_end & ~rx_end_q;
  assign is_term  = (i_rx_data == TERM);
  assign last_idx = rev_q ? (idx_q == '0) : (idx_q == len_q - LEN_W'(1));

  char_buffer_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .i_Clk   (i_Clk),
    .wr_en   (wr_en),
    .wr_addr (len_q[AW-1:0]),
    .wr_data (i_rx_data),
    .rd_en   (rd_en),
    .rd_addr (idx_q[AW-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rev_d     = rev_q;
    app_d     = app_q;
    term_ph_d = term_ph_q;
    wait_d    = wait_q;
    ovf_d     = ovf_q;
    drop_d    = 1'b0;
    send_d    = 1'b0;
    sel_d     = sel_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (is_term) begin
            rev_d     = i_reverse;
            app_d     = i_append_term;
            term_ph_d = 1'b0;
            if (len_q != '0) begin
              idx_d   = i_reverse ? (len_q - LEN_W'(1)) : '0;
              state_d = SEND;
            end else if (i_append_term) begin
              term_ph_d = 1'b1;
              state_d   = SEND;
            end else begin
              ovf_d = 1'b0;
            end
          end else if (len_q != FULL) begin
            wr_en = 1'b1;
            len_d = len_q + LEN_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (!i_txd_busy) begin
          send_d  = 1'b1;
          wait_d  = '0;
          state_d = WAIT_HI;
          if (term_ph_q) begin
            sel_d = SEL_TERM;
          end else begin
            rd_en = 1'b1;
            sel_d = SEL_RAM;
          end
        end
      end
      WAIT_HI: begin
        // A TX core that never reports busy must not stall playback.
        if (i_txd_busy || wait_q == 3'(WAIT_HI_TIMEOUT - 1)) begin
          state_d = WAIT_LO;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      WAIT_LO: begin
        if (!i_txd_busy) begin
          if (!term_ph_q && !last_idx) begin
            idx_d   = rev_q ? (idx_q - LEN_W'(1)) : (idx_q + LEN_W'(1));
            state_d = SEND;
          end else if (app_q && !term_ph_q) begin
            term_ph_d = 1'b1;
            state_d   = SEND;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        len_d   = '0;
        ovf_d   = 1'b0;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase

    if (accept && state_q != COLLECT) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= COLLECT;
      rx_end_q  <= 1'b0;
      len_q     <= '0;
      idx_q     <= '0;
      rev_q     <= 1'b0;
      app_q     <= 1'b0;
      term_ph_q <= 1'b0;
      wait_q    <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
      send_q    <= 1'b0;
      sel_q     <= SEL_ZERO;
    end else begin
      state_q   <= state_d;
      rx_end_q  <= i_rx_end;
      len_q     <= len_d;
      idx_q     <= idx_d;
      rev_q     <= rev_d;
      app_q     <= app_d;
      term_ph_q <= term_ph_d;
      wait_q    <= wait_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
      send_q    <= send_d;
      sel_q     <= sel_d;
    end
  end

  always_comb begin
    case (sel_q)
      SEL_RAM:  o_tx_data = rd_data;
      SEL_TERM: o_tx_data = TERM;
      default:  o_tx_data = '0;
    endcase
  end

  assign o_send_to_computer = send_q;
  assign o_busy             = (state_q != COLLECT);
  assign o_len              = len_q;
  assign o_overflow         = ovf_q;
  assign o_drop             = drop_q;
  assign o_state            = state_q;

endmodule

// File: tb/tb_string_buffer_tx.sv
// Directed bench for string_buffer_tx with a small TX busy model and an expected-byte queue.
module tb_string_buffer_tx;
  import string_tx_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 5;
  localparam int LEN_W  = $clog2(DEPTH + 1);

  logic              i_Clk = 1'b0;
  logic              i_Rst;
  logic [DATA_W-1:0] i_rx_data;
  logic              i_rx_end;
  logic              i_txd_busy;
  logic              i_reverse;
  logic              i_append_term;
  logic [DATA_W-1:0] o_tx_data;
  logic              o_send_to_computer;
  logic              o_busy;
  logic [LEN_W-1:0]  o_len;
  logic              o_overflow;
  logic              o_drop;
  state_t            o_state;

  string_buffer_tx #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TERM   (8'h00)
  ) dut (
    .i_Clk              (i_Clk),
    .i_Rst              (i_Rst),
    .i_rx_data          (i_rx_data),
    .i_rx_end           (i_rx_end),
    .i_txd_busy         (i_txd_busy),
    .i_reverse          (i_reverse),
    .i_append_term      (i_append_term),
    .o_tx_data          (o_tx_data),
    .o_send_to_computer (o_send_to_computer),
    .o_busy             (o_busy),
    .o_len              (o_len),
    .o_overflow         (o_overflow),
    .o_drop             (o_drop),
    .o_state            (o_state)
  );

  // Clock / reset
  always #5 i_Clk = ~i_Clk;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int drop_cnt = 0;
  int unexpected_cnt = 0;
  int busy_len = 10;
  bit busy_en = 1'b1;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // TX core model: busy for busy_len cycles after each start pulse
  initial begin
    i_txd_busy = 1'b0;
    forever begin
      @(negedge i_Clk);
      if (o_send_to_computer && busy_en) begin
        i_txd_busy = 1'b1;
        repeat (busy_len) @(negedge i_Clk);
        i_txd_busy = 1'b0;
      end
    end
  end

  // Scoreboard: every start pulse must carry the next expected byte
  initial begin
    forever begin
      @(negedge i_Clk);
      if (o_drop) drop_cnt++;
      if (o_send_to_computer) begin
        pulse_cnt++;
        if (exp_q.size() > 0) check("tx_data", 32'(o_tx_data), 32'(exp_q.pop_front()));
        else unexpected_cnt++;
      end
    end
  end

  // Driver tasks
  task automatic send_char(input logic [DATA_W-1:0] c);
    @(negedge i_Clk);
    i_rx_data = c;
    i_rx_end  = 1'b1;
    repeat (2) @(negedge i_Clk);
    i_rx_end  = 1'b0;
    repeat (2) @(negedge i_Clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge i_Clk);
    while (o_busy && n < 3000) begin
      @(negedge i_Clk);
      n++;
    end
    check(tag, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int p0, d0, n;
    i_Rst = 1'b1;
    i_rx_data = '0;
    i_rx_end = 1'b0;
    i_reverse = 1'b0;
    i_append_term = 1'b0;
    repeat (3) @(negedge i_Clk);
    check("rst_len", 32'(o_len), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_send", 32'(o_send_to_computer), 32'd0);
    check("rst_txd", 32'(o_tx_data), 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    check("rst_state", 32'(o_state), 32'(COLLECT));
    i_Rst = 1'b0;

    // Forward, no terminator; also measure accept-to-pulse latency
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    p0 = pulse_cnt;
    send_str("ABC");
    check("fwd_len", 32'(o_len), 32'd3);
    @(negedge i_Clk);
    i_rx_data = 8'h00;
    i_rx_end = 1'b1;
    @(negedge i_Clk);
    check("lat_pre", 32'(o_send_to_computer), 32'd0);
    @(negedge i_Clk);
    check("lat_2cyc", 32'(o_send_to_computer), 32'd1);
    i_rx_end = 1'b0;
    wait_idle("fwd_idle");
    check("fwd_pulses", 32'(pulse_cnt - p0), 32'd3);
    check("fwd_len_done", 32'(o_len), 32'd0);
    check("fwd_state", 32'(o_state), 32'(COLLECT));

    // Reverse with appended terminator
    exp_q.push_back(8'h43); exp_q.push_back(8'h42); exp_q.push_back(8'h41); exp_q.push_back(8'h00);
    p0 = pulse_cnt;
    i_reverse = 1'b1;
    i_append_term = 1'b1;
    send_str("ABC");
    send_char(8'h00);
    i_reverse = 1'b0;
    i_append_term = 1'b0;
    wait_idle("rev_idle");
    check("rev_pulses", 32'(pulse_cnt - p0), 32'd4);

    // Overflow at DEPTH=5
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'h41 + i));
    send_str("ABCDE");
    check("ovf_full_len", 32'(o_len), 32'(DEPTH));
    check("ovf_not_yet", 32'(o_overflow), 32'd0);
    send_char(8'h46);
    check("ovf_set", 32'(o_overflow), 32'd1);
    check("ovf_len_sat", 32'(o_len), 32'(DEPTH));
    send_char(8'h47);
    send_char(8'h00);
    check("ovf_held_play", 32'(o_overflow), 32'd1);
    wait_idle("ovf_idle");
    check("ovf_cleared", 32'(o_overflow), 32'd0);

    // Long rx_end high period accepts exactly one character
    @(negedge i_Clk);
    i_rx_data = 8'h41;
    i_rx_end = 1'b1;
    repeat (20) @(negedge i_Clk);
    i_rx_end = 1'b0;
    @(negedge i_Clk);
    check("hold_len", 32'(o_len), 32'd1);
    exp_q.push_back(8'h41);
    send_char(8'h00);
    wait_idle("hold_idle");

    // Character during playback is dropped
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    d0 = drop_cnt;
    send_str("AB");
    send_char(8'h00);
    send_char(8'h5a);
    check("drop_len", 32'(o_len), 32'd2);
    wait_idle("drop_idle");
    check("drop_once", 32'(drop_cnt - d0), 32'd1);
    check("drop_len_done", 32'(o_len), 32'd0);

    // TX never reports busy: WAIT_HI timeout path
    busy_en = 1'b0;
    exp_q.push_back(8'h58); exp_q.push_back(8'h59); exp_q.push_back(8'h5a);
    p0 = pulse_cnt;
    send_str("XYZ");
    send_char(8'h00);
    wait_idle("tmo_idle");
    check("tmo_pulses", 32'(pulse_cnt - p0), 32'd3);
    busy_en = 1'b1;

    // Lone terminator: nothing sent without append, TERM alone with append
    p0 = pulse_cnt;
    send_char(8'h00);
    repeat (10) @(negedge i_Clk);
    check("lone_nopulse", 32'(pulse_cnt - p0), 32'd0);
    check("lone_state", 32'(o_state), 32'(COLLECT));
    exp_q.push_back(8'h00);
    i_append_term = 1'b1;
    send_char(8'h00);
    i_append_term = 1'b0;
    wait_idle("lone_app_idle");
    check("lone_app_pulses", 32'(pulse_cnt - p0), 32'd1);

    // Reset after the second of five bytes
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    p0 = pulse_cnt;
    send_str("ABCDE");
    send_char(8'h00);
    n = 0;
    while ((pulse_cnt - p0) < 2 && n < 2000) begin
      @(negedge i_Clk);
      n++;
    end
    check("mid_two_sent", 32'(pulse_cnt - p0), 32'd2);
    i_Rst = 1'b1;
    @(negedge i_Clk);
    check("mid_rst_len", 32'(o_len), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_send", 32'(o_send_to_computer), 32'd0);
    check("mid_rst_txd", 32'(o_tx_data), 32'd0);
    check("mid_rst_drop", 32'(o_drop), 32'd0);
    i_Rst = 1'b0;
    repeat (100) @(negedge i_Clk);
    check("mid_no_more", 32'(pulse_cnt - p0), 32'd2);

    // Final report
    check("unexpected_pulses", 32'(unexpected_cnt), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/string_buffer_tx.md
Name: string_buffer_tx

Overview:
- Parametrised successor to the single-string echo transmitter.
- Collects characters from the UART receiver into a DEPTH-entry buffer until a configurable terminator byte arrives, then plays the string back to the UART transmitter in forward or reverse order, optionally followed by the terminator.
- Sits between the serial RX core and the TX core on the DE2 serial path.
- Adds over the previous generation: overflow detection, selectable order, a robust busy handshake, and drop accounting.

Parameters:
- DATA_W, 8, character width in bits.
- DEPTH, 256, buffer capacity in characters; ≥2.
- TERM, 8'h00, terminator value (DATA_W bits).
- LEN_W, $clog2(DEPTH+1), width of the length counter.

Ports:
- i_Clk  in  1  sole clock.
- i_Rst  in  1  synchronous, active-high reset.
- i_rx_data  in  DATA_W  received character; valid while i_rx_end is high.
- i_rx_end  in  1  level strobe from the RX core; may stay high for several cycles per character.
- i_txd_busy  in  1  TX core busy.
- i_reverse  in  1  playback order: 0 = oldest first, 1 = newest first. Sampled when the terminator is accepted.
- i_append_term  in  1  1 = send TERM after the string. Sampled when the terminator is accepted.
- o_tx_data  out  DATA_W  character presented to TX.
- o_send_to_computer  out  1  one-cycle TX start pulse.
- o_busy  out  1  high in any state other than COLLECT.
- o_len  out  LEN_W  number of characters currently stored.
- o_overflow  out  1  sticky; set on a character lost to a full buffer.
- o_drop  out  1  one-cycle pulse; a character arrived during playback and was discarded.

Behaviour:
- Reset (i_Rst=1 at a clock edge):
  - State → COLLECT.
  - o_len, o_tx_data, o_send_to_computer, o_busy, o_overflow, o_drop all 0.
  - Buffer contents are don't-care.
  - Reset mid-playback aborts immediately; no further start pulses.
- Character accept:
  - Accept happens on the rising edge of i_rx_end (registered previous value, low in reset).
  - Exactly one accept per high period of i_rx_end.
- COLLECT state, on accept:
  - Data == TERM → latch i_reverse and i_append_term.
    - If o_len > 0 → go to SEND.
    - If o_len == 0 and append is set → send TERM alone.
    - Otherwise stay in COLLECT (no output, o_overflow cleared).
  - Data != TERM and o_len < DEPTH → write mem[o_len], increment o_len.
  - Data != TERM and o_len == DEPTH → discard the character, set o_overflow.
- Playback pointer:
  - Forward: idx = 0 up to o_len-1.
  - Reverse: idx = o_len-1 down to 0.
- SEND:
  - Waits for i_txd_busy == 0.
  - Then drives o_tx_data = mem[idx] (or TERM in the term phase) and pulses o_send_to_computer for one cycle.
  - o_tx_data is stable from the pulse until the next pulse.
  - Go to WAIT_HI.
- WAIT_HI:
  - Wait for i_txd_busy == 1, then go to WAIT_LO.
  - Timeout: after 4 cycles without busy, treat the byte as sent and go to WAIT_LO.
- WAIT_LO:
  - Wait for i_txd_busy == 0.
  - If more characters remain → advance idx, go to SEND.
  - Else if append is latched and TERM not yet sent → term phase, go to SEND.
  - Else → DONE.
- DONE (one cycle):
  - o_len ← 0, o_overflow ← 0.
  - Go to COLLECT.
- Accepts in any state other than COLLECT: discarded, o_drop pulses.
- Accept in the same cycle as DONE → DONE: treated as a drop.
- Latency:
  - Terminator accept edge → first o_send_to_computer at 2 cycles minimum, when i_txd_busy is low.
  - Consecutive start pulses are separated by at least the TX busy period plus 2 cycles.
- Memory:
  - Single write port, single registered read port; infers block RAM.
  - Read address is issued one cycle before the start pulse.
- Arithmetic:
  - o_len saturates at DEPTH.
  - idx is LEN_W bits and never wraps: the last-index check precedes any increment or decrement.

Decomposition:
- Package string_tx_pkg:
  - state enum: COLLECT, SEND, WAIT_HI, WAIT_LO, DONE.
  - WAIT_HI_TIMEOUT = 4.
  - DEFAULT_TERM = 8'h00.
- One sub-module, char_buffer_ram (DATA_W, DEPTH): sync write, registered read.
- The FSM and counters stay in the top level.

Test Plan:
- Rx "ABC" then 8'h00, i_reverse=0, i_append_term=0, TX busy 10 cycles per byte → start pulses carry 41,42,43 in order, then o_len=0 and back to COLLECT.
- Same string with i_reverse=1, i_append_term=1 → start pulses carry 43,42,41,00, then idle.
- DEPTH=4, rx "ABCDEF" then 00 → o_overflow=1 after E; playback is 41,42,43,44; o_overflow clears in DONE.
- i_rx_end held high 20 cycles with data 41 → o_len increments by exactly 1.
- Byte arrives during playback → o_drop pulses once, playback unaffected; i_txd_busy tied low → WAIT_HI timeout and all bytes still sent.
- Lone 00 with i_append_term=0 → no start pulse. i_Rst asserted after the 2nd of 5 bytes sent → all outputs 0 next cycle and no further pulses.
